// File: rtl/memory_block_pkg.sv
// Shared definitions for the byte-addressable memory block: access size
// encodings and the rule deciding whether an access is legal.
package memory_block_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_INVALID = 2'b11
   } access_size_t;

   // Naturally aligned accesses only; word-only builds reject sub-word sizes.
   function automatic logic access_legal(input logic [1:0] lane,
                                         input logic [1:0] size,
                                         input logic       only_words);
      logic ok;
      ok = 1'b0;
      case (access_size_t'(size))
         SIZE_BYTE: ok = !only_words;
         SIZE_HALF: ok = !only_words && (lane[0] == 1'b0);
         SIZE_WORD: ok = (lane == 2'b00);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/memory_lane_decode.sv
// Maps the low address bits and access size onto the byte lanes touched by
// an access; illegal accesses enable no lanes.
module memory_lane_decode
   import memory_block_pkg::*;
#(
   parameter int ONLY_ALLOW_WORDS = 1
) (
   input  logic [1:0] lane_address,
   input  logic [1:0] read_write_size,
   output logic [3:0] lane_enable,
   output logic       legal
);

   always_comb begin
      legal       = access_legal(lane_address, read_write_size, ONLY_ALLOW_WORDS != 0);
      lane_enable = 4'b0000;
      if (legal) begin
         case (access_size_t'(read_write_size))
            SIZE_BYTE: lane_enable = 4'b0001 << lane_address;
            SIZE_HALF: lane_enable = lane_address[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: lane_enable = 4'b1111;
            default:   lane_enable = 4'b0000;
         endcase
      end
   end

endmodule

// File: rtl/memory_block.sv
// Little-endian byte-addressed word memory with combinational read and
// asynchronous clear; sub-word data is right-justified on both ports.
module memory_block
   import memory_block_pkg::*;
#(
   parameter int ADDRESS_WIDTH    = 10,
   parameter int ONLY_ALLOW_WORDS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [1:0]               read_write_size,
   input  logic                     write_enable,
   input  logic [31:0]              write_value,
   output logic [31:0]              read_value
);

   localparam int WORDS = 2 ** (ADDRESS_WIDTH - 2);

   logic [31:0]              storage [WORDS];
   logic [3:0]               lane_enable;
   logic                     legal;
   logic [ADDRESS_WIDTH-3:0] word_index;
   logic [4:0]               lane_shift;
   logic [31:0]              shifted_write;
   logic [31:0]              lane_mask;
   logic [31:0]              masked_read;

   memory_lane_decode #(
      .ONLY_ALLOW_WORDS(ONLY_ALLOW_WORDS)
   ) u_lane_decode (
      .lane_address   (address[1:0]),
      .read_write_size(read_write_size),
      .lane_enable    (lane_enable),
      .legal          (legal)
   );

   assign word_index    = address[ADDRESS_WIDTH-1:2];
   assign lane_shift    = {address[1:0], 3'b000};
   assign shifted_write = write_value << lane_shift;
   assign lane_mask     = {{8{lane_enable[3]}}, {8{lane_enable[2]}},
                           {8{lane_enable[1]}}, {8{lane_enable[0]}}};
   assign masked_read   = storage[word_index] & lane_mask;

   // Reset clears every word and blocks the output so nothing leaks while it is held.
   assign read_value = reset ? 32'h0 : (masked_read >> lane_shift);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            storage[i] <= 32'h0;
         end
      end else if (write_enable && legal) begin
         for (int l = 0; l < 4; l++) begin
            if (lane_enable[l]) begin
               storage[word_index][8*l +: 8] <= shifted_write[8*l +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_block.sv
// Scoreboard bench: one memory allowing sub-word accesses and one word-only,
// both driven together and compared against a byte-array reference.
module tb_memory_block;

   logic        clk;
   logic        reset;
   logic [9:0]  address;
   logic [1:0]  read_write_size;
   logic        write_enable;
   logic [31:0] write_value;
   logic [31:0] read_value_any;
   logic [31:0] read_value_words;

   int checks;
   int failures;

   logic [7:0]  model [2][1024];
   logic [31:0] exp_q [$];
   int          dut_q [$];
   string       name_q [$];
   event        sample_ev;

   memory_block #(.ADDRESS_WIDTH(10), .ONLY_ALLOW_WORDS(0)) dut_any (
      .clk(clk), .reset(reset), .address(address),
      .read_write_size(read_write_size), .write_enable(write_enable),
      .write_value(write_value), .read_value(read_value_any)
   );

   memory_block #(.ADDRESS_WIDTH(10), .ONLY_ALLOW_WORDS(1)) dut_words (
      .clk(clk), .reset(reset), .address(address),
      .read_write_size(read_write_size), .write_enable(write_enable),
      .write_value(write_value), .read_value(read_value_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int size_bytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit model_legal(input int d, input logic [9:0] a, input logic [1:0] s);
      if (s == 2'd3) return 1'b0;
      if (d == 1 && s != 2'd2) return 1'b0;
      return (int'(a) % size_bytes(s)) == 0;
   endfunction

   function automatic logic [31:0] model_read(input int d, input logic [9:0] a, input logic [1:0] s);
      logic [31:0] r;
      r = 32'h0;
      if (reset || !model_legal(d, a, s)) return 32'h0;
      for (int i = 0; i < size_bytes(s); i++) begin
         r = r | (32'(model[d][int'(a) + i]) << (8 * i));
      end
      return r;
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 1024; i++)
            model[d][i] = 8'h00;
   endtask

   task automatic apply_stimulus(input logic [9:0] a, input logic [1:0] s, input logic [31:0] v);
      @(negedge clk);
      address         = a;
      read_write_size = s;
      write_value     = v;
      write_enable    = 1'b1;
      @(posedge clk);
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (model_legal(d, a, s)) begin
               for (int i = 0; i < size_bytes(s); i++)
                  model[d][int'(a) + i] = v[8*i +: 8];
            end
         end
      end
      #1 write_enable = 1'b0;
   endtask

   task automatic check_output(input logic [9:0] a, input logic [1:0] s, input string name,
                               input bit wait_edge);
      if (wait_edge) @(negedge clk);
      address         = a;
      read_write_size = s;
      write_enable    = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_q.push_back(model_read(d, a, s));
         dut_q.push_back(d);
         name_q.push_back(name);
      end
      ->sample_ev;
   endtask

   // Monitor: drains the scoreboard whenever the stimulus side posts a read.
   initial begin
      forever begin
         @(sample_ev);
         while (exp_q.size() > 0) begin
            logic [31:0] expv, actv;
            int          d;
            string       nm;
            expv = exp_q.pop_front();
            d    = dut_q.pop_front();
            nm   = name_q.pop_front();
            actv = (d == 0) ? read_value_any : read_value_words;
            checks++;
            if (actv !== expv) begin
               failures++;
               $display("[TB] FAIL %s dut%0d addr=%h size=%0d got=%h expected=%h",
                        nm, d, address, read_write_size, actv, expv);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] s;
      int         n;
      int         budget;
      checks = 0;
      failures = 0;
      address = '0;
      read_write_size = 2'd2;
      write_enable = 1'b0;
      write_value = '0;
      clear_model();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      check_output(10'h010, 2'd2, "during_reset", 1'b1);
      reset = 1'b0;
      check_output(10'h010, 2'd2, "after_reset", 1'b1);

      // Directed word and byte-lane cases
      apply_stimulus(10'h010, 2'd2, 32'hDEADBEEF);
      check_output(10'h010, 2'd2, "word_rw", 1'b1);
      apply_stimulus(10'h020, 2'd0, 32'h11);
      apply_stimulus(10'h021, 2'd0, 32'h22);
      apply_stimulus(10'h022, 2'd0, 32'h33);
      apply_stimulus(10'h023, 2'd0, 32'h44);
      check_output(10'h020, 2'd2, "bytes_as_word", 1'b1);
      check_output(10'h022, 2'd1, "half_read", 1'b1);
      check_output(10'h021, 2'd0, "byte_read", 1'b1);

      // Misaligned and invalid-size accesses
      apply_stimulus(10'h030, 2'd2, 32'hCAFEF00D);
      apply_stimulus(10'h031, 2'd1, 32'hABCD);
      check_output(10'h030, 2'd2, "misaligned_no_write", 1'b1);
      check_output(10'h031, 2'd1, "misaligned_read", 1'b1);
      check_output(10'h030, 2'd3, "size11_read", 1'b1);
      apply_stimulus(10'h030, 2'd3, 32'h12345678);
      check_output(10'h030, 2'd2, "size11_no_write", 1'b1);

      // Word-only instance must ignore sub-word traffic
      apply_stimulus(10'h040, 2'd2, 32'h0BADCAFE);
      apply_stimulus(10'h040, 2'd0, 32'hFF);
      check_output(10'h040, 2'd2, "byte_write_word_only", 1'b1);
      check_output(10'h040, 2'd0, "byte_read_word_only", 1'b1);

      // Random image built from mixed access sizes
      for (int w = 0; w < 256; w++) begin
         s = 2'($urandom_range(0, 2));
         n = size_bytes(s);
         for (int off = 0; off < 4; off += n)
            apply_stimulus(10'(w * 4 + off), s, $urandom);
      end
      for (int w = 0; w < 256; w++)
         check_output(10'(w * 4), 2'd2, "image_word", 1'b1);
      for (int k = 0; k < 256; k++)
         check_output(10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)), "image_random", 1'b1);

      // Reset pulse in mid-cycle clears storage without a clock edge
      @(posedge clk);
      #2 reset = 1'b1;
      clear_model();
      check_output(10'h010, 2'd2, "reset_held", 1'b0);
      reset = 1'b0;
      check_output(10'h010, 2'd2, "reset_pulse_immediate", 1'b0);
      for (int w = 0; w < 256; w++)
         check_output(10'(w * 4), 2'd2, "cleared_word", 1'b1);

      // Write coinciding with reset assertion is lost
      @(negedge clk);
      address = 10'h050;
      read_write_size = 2'd2;
      write_value = 32'h12345678;
      write_enable = 1'b1;
      @(posedge clk);
      reset = 1'b1;
      #2;
      write_enable = 1'b0;
      reset = 1'b0;
      check_output(10'h050, 2'd2, "reset_wins", 1'b1);

      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_block.md
MEMORY_BLOCK -- requirements
Module: memory_block

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10: byte-address width; capacity SHALL be 2**(ADDRESS_WIDTH-2) 32-bit words.
REQ-002 Parameter ONLY_ALLOW_WORDS, default 1: when 1, only word accesses are legal; when 0, byte, halfword and word accesses are legal.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  ADDRESS_WIDTH  byte address of access.
REQ-006 read_write_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 invalid.
REQ-007 write_enable  input  1  1 = write on next rising edge.
REQ-008 write_value  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-009 read_value  output  32  read data, right-justified, zero-extended.

Function
REQ-010 Storage SHALL be little-endian byte-addressed: byte at address A lives in word A[ADDRESS_WIDTH-1:2], lane A[1:0], bits [8*lane+7 : 8*lane].
REQ-011 Write: on rising clk with write_enable=1 and a legal access, the addressed bytes SHALL update from write_value (byte: [7:0]; halfword: [15:0] into lanes A, A+1; word: all four lanes); other bytes unchanged.
REQ-012 Read SHALL be combinational from address, read_write_size and storage: word returns full word; halfword returns {16'b0, bytes A+1..A}; byte returns {24'b0, byte A}.
REQ-013 A write SHALL be visible on read_value immediately after the rising edge that performs it (read-after-write, zero cycles of extra latency).
REQ-014 Alignment: halfword requires A[0]=0; word requires A[1:0]=00; misaligned access SHALL not write and SHALL read 32'h0.
REQ-015 read_write_size=11 SHALL not write and SHALL read 32'h0.
REQ-016 With ONLY_ALLOW_WORDS=1, byte/halfword sizes SHALL be treated as illegal (no write, read 32'h0).
REQ-017 Whether write_enable is high or low SHALL not affect read_value combinationally other than through stored data after the edge.

Reset
REQ-018 Asserting reset SHALL immediately clear every storage word to 32'h0, independent of clk.
REQ-019 While reset is high, writes SHALL be ignored and read_value SHALL be 32'h0.
REQ-020 A write edge coinciding with reset assertion SHALL be lost; reset wins.

Structure
REQ-021 A shared package SHALL hold the size encodings (SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10) and the access-legality function.
REQ-022 A sub-module memory_lane_decode SHALL map (address[1:0], read_write_size, ONLY_ALLOW_WORDS) to a 4-bit byte-lane enable plus a legal flag; memory_block uses it for both write masking and read extraction.

Verification
REQ-023 ADDRESS_WIDTH=10, ONLY_ALLOW_WORDS=0: reset, write word 0xDEADBEEF at 0x010, read word at 0x010 -> 0xDEADBEEF.
REQ-024 Write bytes 0x11,0x22,0x33,0x44 at 0x020..0x023, read word 0x020 -> 0x44332211; read half 0x022 -> 0x00004433; read byte 0x021 -> 0x00000022.
REQ-025 Random image over all 256 words written with random mix of byte/half/word accesses, each word read back as word, then re-read with random sizes -> matches image, zero-extended.
REQ-026 Write half 0xABCD at 0x031 (misaligned) -> word at 0x030 unchanged; read half at 0x031 -> 0x0; size 11 read -> 0x0.
REQ-027 Fill memory, pulse reset mid-cycle -> every word reads 0x0 immediately, without a clock edge.
REQ-028 ONLY_ALLOW_WORDS=1: byte write 0xFF at 0x040 -> word at 0x040 unchanged; byte read -> 0x0; word write/read works.
